div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Multi-cycle 32-bit integer divider; the division counterpart of the combinational multiplier in the EX stage.
//  Serves LoongArch DIV.W/DIV.WU/MOD.W/MOD.WU. Radix-2 restoring algorithm on magnitudes, then a sign fix-up.
//  Uses a start/done handshake. EX stalls while busy=1. A pipeline flush aborts an operation through cancel.
// PARAMETERS
//  WIDTH  32  operand/result width; counter width = $clog2(WIDTH)
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      request; accepted only when busy=0 and cancel=0
//  signed_div_i   in   1      1 = signed two's-complement, 0 = unsigned
//  opdata1_div    in   WIDTH  dividend, sampled on accept
//  opdata2_div    in   WIDTH  divisor, sampled on accept
//  cancel         in   1      flush; aborts any operation in flight
//  busy           out  1      1 in CALC and DONE states
//  done           out  1      1-cycle pulse, results valid
//  quotient       out  WIDTH  registered, held until next accept
//  remainder      out  WIDTH  registered, held until next accept
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0. Applies mid-operation; no done follows.
//  States:
//   IDLE -> CALC on accept (divisor!=0). Latch |dividend|, |divisor|, q_neg, r_neg; counter=0.
//   IDLE -> DONE on accept with divisor==0.
//   CALC: one step per cycle. Partial remainder {r,q} shifts left 1. Trial subtract r-|d|; if no borrow, r=diff and q lsb=1.
//   CALC -> DONE after step 31 (counter==WIDTH-1). Sign fix-up happens on that edge.
//   DONE -> IDLE unconditionally. done=1 only in DONE.
//  Magnitudes: |x| = ~x+1 only when signed_div_i=1 and x[MSB]=1; otherwise x.
//   0x80000000 is treated as unsigned magnitude 2^31.
//  Signs: q_neg = signed & (a[MSB]^b[MSB]); r_neg = signed & a[MSB].
//   Negate the raw quotient/remainder (~v+1) when the flag is set.
//  Latency (start high in cycle 0): normal -> done in cycle 33; divisor zero -> done in cycle 1.
//   busy rises in cycle 1 and falls in the cycle after done.
//  Divide by zero: quotient=all ones, remainder=dividend unchanged. Same for signed and unsigned.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Needs no special case.
//  cancel in CALC: next state IDLE, no done, quotient/remainder keep old values.
//  cancel with start in IDLE: not accepted.
//  cancel in DONE: done already visible this cycle; next state IDLE as normal.
//  start while busy=1: ignored. Operands are not re-sampled.
//  Outputs change only on an edge into DONE or on reset. No combinational path from inputs to outputs.
// STRUCTURE
//  div_defs.vh: `define state encodings DIV_IDLE/DIV_CALC/DIV_DONE (2 bits), `define DIV_WIDTH 32.
//  Sub-module div_step: combinational one-bit restoring step.
//   In: {r,q}, |d|. Out: next {r,q}.
//  div_iter holds the FSM, counter, operand registers, fix-up and output registers.
// TESTING
//  Unsigned 100/7, start cycle 0 -> done cycle 33. quotient=14, remainder=2, busy=0 in cycle 34.
//  Signed 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
//   Unsigned same operands -> quotient=0x7FFFFFFC, remainder=1.
//  Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//   Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
//  0x12345678/0 (both modes) -> done cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678.
//  cancel in cycle 10 of 100/7 -> no done, busy=0 in cycle 11, outputs unchanged.
//   Then 9/3 -> quotient=3, remainder=0 at +33.
//  reset asserted in cycle 15 of an op -> busy/done/quotient/remainder=0 immediately. start during busy is ignored (scoreboard).

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: datapath width and FSM state encoding.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Start/done handshake between the EX stage and the iterative divider.
interface div_iter_if
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_div_i;
  logic [WIDTH-1:0] opdata1_div;
  logic [WIDTH-1:0] opdata2_div;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div_i, opdata1_div, opdata2_div, cancel,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div_i, opdata1_div, opdata2_div, cancel,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step on magnitudes: shift {r,q} left, keep r-d when it does not borrow.
module div_iter_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // The shifted remainder needs one extra bit; the top bit of the difference is the borrow.
  assign w_shift  = {i_rem, i_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, i_div};
  assign w_borrow = w_diff[WIDTH];

  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle integer divider (DIV/MOD, signed and unsigned) with start/done handshake and flush cancel.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_busy;
  logic             w_done;

  assign w_accept   = bus.start & ~bus.cancel & (r_state == DIV_IDLE);
  assign w_div_zero = (bus.opdata2_div == {WIDTH{1'b0}});
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude 2^31.
  assign w_a_mag = (bus.signed_div_i & bus.opdata1_div[WIDTH-1]) ? (~bus.opdata1_div + WIDTH'(1))
                                                                 : bus.opdata1_div;
  assign w_b_mag = (bus.signed_div_i & bus.opdata2_div[WIDTH-1]) ? (~bus.opdata2_div + WIDTH'(1))
                                                                 : bus.opdata2_div;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  assign w_q_fix = r_q_neg ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
  assign w_r_fix = r_r_neg ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero ? DIV_DONE : DIV_CALC;
        end else begin
          w_state_nxt = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        if (bus.cancel) begin
          w_state_nxt = DIV_IDLE;
        end else if (w_last) begin
          w_state_nxt = DIV_DONE;
        end else begin
          w_state_nxt = DIV_CALC;
        end
      end
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      DIV_CALC: w_busy = 1'b1;
      DIV_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Operand latching, iteration and result registers; results move only on an edge into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_div       <= {WIDTH{1'b0}};
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_rem   <= {WIDTH{1'b0}};
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_q_neg <= bus.signed_div_i & (bus.opdata1_div[WIDTH-1] ^ bus.opdata2_div[WIDTH-1]);
            r_r_neg <= bus.signed_div_i & bus.opdata1_div[WIDTH-1];
            if (w_div_zero) begin
              r_quotient  <= {WIDTH{1'b1}};
              r_remainder <= bus.opdata1_div;
            end
          end
        end
        DIV_CALC: begin
          if (!bus.cancel) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_quotient  <= w_q_fix;
              r_remainder <= w_r_fix;
            end
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;

endmodule
